// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Hazard detection and operand forwarding unit for the
//                pipelined RISC-V core, sitting beside decode. Tracks
//                in-flight destinations in a FWD_DEPTH-entry shift register
//                and keeps a busy scoreboard for long (mul/div) operations.
//                Produces per-source one-hot bypass selects, a from-memory
//                flag per source, a global issue stall and a saturating
//                stall-cycle counter.
//  Ports       : clk, reset (sync, active-high)
//                dec_*        : decode instruction (sources, dest, kind)
//                flush        : kill entry 1 and the decode instruction
//                lng_done/rd  : long-op completion (clears busy bit)
//                stall, issue_fire, fwd_sel, fwd_mem, busy, stall_cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 3,
    parameter int LOAD_LAT  = 2,
    parameter int CNT_W     = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dec_valid,
    input  logic [NUM_SRC*5-1:0]           dec_src,
    input  logic [NUM_SRC-1:0]             dec_use,
    input  logic [4:0]                     dec_rd,
    input  logic                           dec_wr,
    input  logic                           dec_load,
    input  logic                           dec_long,
    input  logic                           flush,
    input  logic                           lng_done,
    input  logic [4:0]                     lng_rd,
    output logic                           stall,
    output logic                           issue_fire,
    output logic [NUM_SRC*FWD_DEPTH-1:0]   fwd_sel,
    output logic [NUM_SRC-1:0]             fwd_mem,
    output logic [31:0]                    busy,
    output logic [CNT_W-1:0]               stall_cycles
);

    // Pipeline entries; array index k-1 holds entry k (1 = youngest).
    logic [FWD_DEPTH-1:0] r_vld;
    logic [FWD_DEPTH-1:0] r_wr;
    logic [FWD_DEPTH-1:0] r_ld;
    logic [FWD_DEPTH-1:0] r_lng;
    logic [4:0]           r_rd [FWD_DEPTH];

    logic [31:0]          r_busy;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic [NUM_SRC*FWD_DEPTH-1:0] w_fwd_sel;
    logic [NUM_SRC-1:0]           w_fwd_mem;
    logic                         w_load_use;
    logic                         w_busy_haz;
    logic                         w_stall;
    logic                         w_issue_fire;
    logic [31:0]                  w_busy_nxt;

    // Forwarding match and hazard detection. The ascending scan with a
    // found flag makes the youngest matching entry win.
    always_comb begin
        logic       w_found;
        logic [4:0] w_src;
        w_fwd_sel  = '0;
        w_fwd_mem  = '0;
        w_load_use = 1'b0;
        w_busy_haz = 1'b0;
        w_found    = 1'b0;
        w_src      = 5'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_found = 1'b0;
            w_src   = dec_src[5*i +: 5];
            for (int k = 0; k < FWD_DEPTH; k++) begin
                if (!w_found && dec_use[i] && (w_src != 5'd0) &&
                    r_vld[k] && r_wr[k] && (r_rd[k] == w_src)) begin
                    w_found               = 1'b1;
                    w_fwd_sel[i*FWD_DEPTH + k] = 1'b1;
                    w_fwd_mem[i]          = r_ld[k];
                    // Load data is not yet available this close to decode.
                    if (r_ld[k] && ((k + 1) < LOAD_LAT)) begin
                        w_load_use = 1'b1;
                    end
                end
            end
            if (dec_use[i] && (w_src != 5'd0) && r_busy[w_src]) begin
                w_busy_haz = 1'b1;
            end
        end
        // WAW against an outstanding long op.
        if (dec_wr && (dec_rd != 5'd0) && r_busy[dec_rd]) begin
            w_busy_haz = 1'b1;
        end
    end

    assign w_stall      = dec_valid && (w_load_use || w_busy_haz);
    assign w_issue_fire = dec_valid && !w_stall && !flush && !reset;

    // Busy next-state: clears first, then the set, so a same-cycle set of
    // the same register wins. A flushed entry-1 long op will never complete,
    // so its bit is released here.
    always_comb begin
        w_busy_nxt = r_busy;
        if (lng_done) begin
            w_busy_nxt[lng_rd] = 1'b0;
        end
        if (flush && r_vld[0] && r_lng[0]) begin
            w_busy_nxt[r_rd[0]] = 1'b0;
        end
        if (w_issue_fire && dec_long && (dec_rd != 5'd0)) begin
            w_busy_nxt[dec_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld       <= '0;
            r_wr        <= '0;
            r_ld        <= '0;
            r_lng       <= '0;
            for (int k = 0; k < FWD_DEPTH; k++) begin
                r_rd[k] <= 5'd0;
            end
            r_busy      <= '0;
            r_stall_cnt <= '0;
        end else begin
            // Entry 1: issued instruction or a bubble. Long ops never
            // forward, so they enter with wr cleared.
            r_vld[0] <= w_issue_fire;
            r_wr[0]  <= dec_wr && !dec_long;
            r_ld[0]  <= dec_load;
            r_lng[0] <= dec_long;
            r_rd[0]  <= dec_rd;
            // Entries always advance; a flushed entry 1 becomes a bubble.
            for (int k = 1; k < FWD_DEPTH; k++) begin
                r_vld[k] <= (k == 1 && flush) ? 1'b0 : r_vld[k-1];
                r_wr[k]  <= r_wr[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_lng[k] <= r_lng[k-1];
                r_rd[k]  <= r_rd[k-1];
            end
            r_busy <= w_busy_nxt;
            if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign stall        = w_stall;
    assign issue_fire   = w_issue_fire;
    assign fwd_sel      = w_fwd_sel;
    assign fwd_mem      = w_fwd_mem;
    assign busy         = r_busy;
    assign stall_cycles = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Self-checking bench for hazard_scoreboard. A table of
//                per-cycle vectors (inputs plus expected outputs) is applied
//                in order; reset and counter saturation are covered by
//                hand-written sequences. A second instance with a 2-bit
//                counter checks saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        dec_valid;
    logic [9:0]  dec_src;
    logic [1:0]  dec_use;
    logic [4:0]  dec_rd;
    logic        dec_wr, dec_load, dec_long;
    logic        flush, lng_done;
    logic [4:0]  lng_rd;

    logic        stall, issue_fire;
    logic [5:0]  fwd_sel;
    logic [1:0]  fwd_mem;
    logic [31:0] busy;
    logic [31:0] stall_cycles;

    logic        stall_2, issue_fire_2;
    logic [5:0]  fwd_sel_2;
    logic [1:0]  fwd_mem_2;
    logic [31:0] busy_2;
    logic [1:0]  stall_cycles_2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_SRC(2), .FWD_DEPTH(3), .LOAD_LAT(2), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src(dec_src),
        .dec_use(dec_use), .dec_rd(dec_rd), .dec_wr(dec_wr), .dec_load(dec_load),
        .dec_long(dec_long), .flush(flush), .lng_done(lng_done), .lng_rd(lng_rd),
        .stall(stall), .issue_fire(issue_fire), .fwd_sel(fwd_sel), .fwd_mem(fwd_mem),
        .busy(busy), .stall_cycles(stall_cycles)
    );

    hazard_scoreboard #(.NUM_SRC(2), .FWD_DEPTH(3), .LOAD_LAT(2), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src(dec_src),
        .dec_use(dec_use), .dec_rd(dec_rd), .dec_wr(dec_wr), .dec_load(dec_load),
        .dec_long(dec_long), .flush(flush), .lng_done(lng_done), .lng_rd(lng_rd),
        .stall(stall_2), .issue_fire(issue_fire_2), .fwd_sel(fwd_sel_2), .fwd_mem(fwd_mem_2),
        .busy(busy_2), .stall_cycles(stall_cycles_2)
    );

    typedef struct {
        logic        flush;
        logic        valid;
        logic [4:0]  s0;
        logic [4:0]  s1;
        logic [1:0]  use_b;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
        logic        lng;
        logic        done;
        logic [4:0]  lrd;
        logic        e_stall;
        logic        e_fire;
        logic [5:0]  e_sel;
        logic [1:0]  e_mem;
        logic [31:0] e_busy;
        logic [31:0] e_cnt;
    } vec_t;

    localparam int N_VEC = 27;
    vec_t tv [N_VEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        flush     = v.flush;
        dec_valid = v.valid;
        dec_src   = {v.s1, v.s0};
        dec_use   = v.use_b;
        dec_rd    = v.rd;
        dec_wr    = v.wr;
        dec_load  = v.ld;
        dec_long  = v.lng;
        lng_done  = v.done;
        lng_rd    = v.lrd;
    endtask

    task automatic idle();
        flush = 0; dec_valid = 0; dec_src = '0; dec_use = '0; dec_rd = '0;
        dec_wr = 0; dec_load = 0; dec_long = 0; lng_done = 0; lng_rd = '0;
    endtask

    initial begin
        //             fl v  s0 s1  use rd wr ld lg dn lrd | stl fire sel        mem    busy      cnt
        tv[0]  = '{0, 1, 0, 0, 2'b00, 5, 1, 0, 0, 0, 0,  0, 1, 6'b000000, 2'b00, 32'h0,        1'b0 ? 32'd0 : 32'd0};
        tv[1]  = '{0, 1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0,  0, 1, 6'b000001, 2'b00, 32'h0,        32'd0};
        tv[2]  = '{0, 1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0,  0, 1, 6'b000010, 2'b00, 32'h0,        32'd0};
        tv[3]  = '{0, 1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0,  0, 1, 6'b000100, 2'b00, 32'h0,        32'd0};
        tv[4]  = '{0, 1, 5, 0, 2'b01, 0, 0, 0, 0, 0, 0,  0, 1, 6'b000000, 2'b00, 32'h0,        32'd0};
        // load-use
        tv[5]  = '{0, 1, 0, 0, 2'b00, 7, 1, 1, 0, 0, 0,  0, 1, 6'b000000, 2'b00, 32'h0,        32'd0};
        tv[6]  = '{0, 1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 0,  1, 0, 6'b001000, 2'b10, 32'h0,        32'd0};
        tv[7]  = '{0, 1, 0, 7, 2'b10, 0, 0, 0, 0, 0, 0,  0, 1, 6'b010000, 2'b10, 32'h0,        32'd1};
        // youngest wins, x0 filtering
        tv[8]  = '{0, 1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0,  0, 1, 6'b000000, 2'b00, 32'h0,        32'd1};
        tv[9]  = '{0, 1, 0, 0, 2'b00, 3, 1, 0, 0, 0, 0,  0, 1, 6'b000000, 2'b00, 32'h0,        32'd1};
        tv[10] = '{0, 1, 3, 0, 2'b01, 0, 0, 0, 0, 0, 0,  0, 1, 6'b000001, 2'b00, 32'h0,        32'd1};
        tv[11] = '{0, 1, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0,  0, 1, 6'b000000, 2'b00, 32'h0,        32'd1};
        tv[12] = '{0, 1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0,  0, 1, 6'b000000, 2'b00, 32'h0,        32'd1};
        // long op RAW / WAW interlock and release
        tv[13] = '{0, 1, 0, 0, 2'b00, 9, 1, 0, 1, 0, 0,  0, 1, 6'b000000, 2'b00, 32'h0,        32'd1};
        tv[14] = '{0, 1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0,  1, 0, 6'b000000, 2'b00, 32'h200,      32'd1};
        tv[15] = '{0, 1, 0, 0, 2'b00, 9, 1, 0, 0, 0, 0,  1, 0, 6'b000000, 2'b00, 32'h200,      32'd2};
        tv[16] = '{0, 1, 9, 0, 2'b01, 0, 0, 0, 0, 1, 9,  1, 0, 6'b000000, 2'b00, 32'h200,      32'd3};
        tv[17] = '{0, 1, 9, 0, 2'b01, 0, 0, 0, 0, 0, 0,  0, 1, 6'b000000, 2'b00, 32'h0,        32'd4};
        // flush of a load in entry 1
        tv[18] = '{0, 1, 0, 0, 2'b00, 4, 1, 1, 0, 0, 0,  0, 1, 6'b000000, 2'b00, 32'h0,        32'd4};
        tv[19] = '{1, 1, 4, 0, 2'b01, 0, 0, 0, 0, 0, 0,  1, 0, 6'b000001, 2'b01, 32'h0,        32'd4};
        tv[20] = '{0, 1, 4, 0, 2'b01, 0, 0, 0, 0, 0, 0,  0, 1, 6'b000000, 2'b00, 32'h0,        32'd5};
        // flush of a long op in entry 1 releases its busy bit
        tv[21] = '{0, 1, 0, 0, 2'b00, 6, 1, 0, 1, 0, 0,  0, 1, 6'b000000, 2'b00, 32'h0,        32'd5};
        tv[22] = '{1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 6'b000000, 2'b00, 32'h40,       32'd5};
        // same-cycle set and clear: set wins
        tv[23] = '{0, 1, 0, 0, 2'b00, 11, 1, 0, 1, 1, 11, 0, 1, 6'b000000, 2'b00, 32'h0,       32'd5};
        tv[24] = '{0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 6'b000000, 2'b00, 32'h800,      32'd5};
        tv[25] = '{0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 11, 0, 0, 6'b000000, 2'b00, 32'h800,      32'd5};
        tv[26] = '{0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 0, 6'b000000, 2'b00, 32'h0,        32'd5};

        // Reset and check the reset state.
        idle();
        reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 0;
        #1;
        chk("rst_busy",    busy, 32'h0);
        chk("rst_cnt",     stall_cycles, 32'd0);
        chk("rst_sel",     {26'd0, fwd_sel}, 32'd0);
        chk("rst_stall",   {31'd0, stall}, 32'd0);
        @(posedge clk); #1;

        for (int r = 0; r < N_VEC; r++) begin
            drive(tv[r]);
            #1;
            chk($sformatf("v%0d_stall", r), {31'd0, stall}, {31'd0, tv[r].e_stall});
            chk($sformatf("v%0d_fire", r),  {31'd0, issue_fire}, {31'd0, tv[r].e_fire});
            chk($sformatf("v%0d_sel", r),   {26'd0, fwd_sel}, {26'd0, tv[r].e_sel});
            chk($sformatf("v%0d_mem", r),   {30'd0, fwd_mem}, {30'd0, tv[r].e_mem});
            chk($sformatf("v%0d_busy", r),  busy, tv[r].e_busy);
            chk($sformatf("v%0d_cnt", r),   stall_cycles, tv[r].e_cnt);
            @(posedge clk); #1;
        end

        // Five stall cycles so far: the 2-bit counter is pinned at 3.
        chk("sat_cnt", {30'd0, stall_cycles_2}, 32'd3);

        // Reset with a long op outstanding and valid entries in flight.
        idle();
        dec_valid = 1; dec_rd = 9; dec_wr = 1; dec_long = 1;     // DIV x9
        @(posedge clk); #1;
        dec_long = 0; dec_rd = 5;                                // ADD x5
        @(posedge clk); #1;
        chk("pre_rst_busy", busy, 32'h200);
        reset = 1;                                               // decode still valid
        #1;
        chk("rst_cycle_fire", {31'd0, issue_fire}, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        idle();
        dec_src = {5'd9, 5'd5}; dec_use = 2'b11;
        lng_done = 1; lng_rd = 9;                                // late completion
        #1;
        chk("post_rst_busy", busy, 32'h0);
        chk("post_rst_sel",  {26'd0, fwd_sel}, 32'd0);
        chk("post_rst_cnt",  stall_cycles, 32'd0);
        chk("post_rst_sat",  {30'd0, stall_cycles_2}, 32'd0);
        @(posedge clk); #1;
        dec_valid = 1; lng_done = 0;
        #1;
        chk("late_done_busy",  busy, 32'h0);
        chk("late_done_stall", {31'd0, stall}, 32'd0);
        chk("late_done_fire",  {31'd0, issue_fire}, 32'd1);
        @(posedge clk); #1;
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding unit for the pipelined RISC-V core, sitting beside decode. It tracks in-flight destination registers in its own FWD_DEPTH-entry shift register and holds a busy scoreboard for multi-cycle (long) ops such as mul/div. From these it generates, for NUM_SRC source operands, one-hot bypass selects, a from-memory flag and a global issue stall. It adds x0 filtering, a load-latency parameter, long-op WAW/RAW interlock, flush handling and a stall performance counter.

## Interface
- NUM_SRC, 2: number of source operands checked per instruction.
- FWD_DEPTH, 3: number of tracked in-flight stages; entry k = instruction issued k advancing cycles ago, k = 1..FWD_DEPTH.
- LOAD_LAT, 2: load data is forwardable only from entries k >= LOAD_LAT; 1 <= LOAD_LAT <= FWD_DEPTH.
- CNT_W, 32: stall counter width.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- dec_valid  in  1  decode holds an instruction.
- dec_src  in  NUM_SRC*5  packed source addresses; source i is bits [5i+4:5i].
- dec_use  in  NUM_SRC  source i is actually read.
- dec_rd  in  5  destination address.
- dec_wr  in  1  instruction writes rd.
- dec_load  in  1  instruction is a load.
- dec_long  in  1  instruction is a long op (result returns via lng_*).
- flush  in  1  kill the entry-1 instruction and the decode instruction this cycle.
- lng_done  in  1  a long op completes this cycle.
- lng_rd  in  5  destination of the completing long op.
- stall  out  1  decode must hold.
- issue_fire  out  1  dec_valid && !stall && !flush && !reset.
- fwd_sel  out  NUM_SRC*FWD_DEPTH  one-hot per source, bit [i*FWD_DEPTH + k-1] = take from entry k; all-zero = register file.
- fwd_mem  out  NUM_SRC  selected entry is a load (take M-stage data, not EX).
- busy  out  32  long-op scoreboard; bit 0 always 0.
- stall_cycles  out  CNT_W  saturating count of cycles with dec_valid && stall.

## Operation
- Entry fields: valid, wr, rd, load. Long ops enter with wr=0: they never forward and write back via lng_*.
- Match(i,k): dec_use[i] && src_i != 0 && entry k valid && wr && rd == src_i.
- Per source, the lowest matching k (youngest) wins. fwd_sel is one-hot on it and fwd_mem = entry k load.
- Load-use hazard (i): winning entry is a load with k < LOAD_LAT. The select is still driven, but stall asserts.
- Busy hazard: any used nonzero src_i with busy[src_i]=1, or dec_wr && dec_rd != 0 && busy[dec_rd] (WAW).
- stall = dec_valid && (any load-use hazard || busy hazard). Combinational.
- Shift on every non-reset cycle: entry k+1 <= entry k; the oldest entry is dropped.
- Entry 1 loads the decode instruction if issue_fire, else a bubble (valid=0).
- Entries only advance; stall inserts bubbles and never freezes them.
- flush: entry 1 is not propagated (entry 2 becomes a bubble), and decode does not issue. Deeper entries are unaffected.
- Busy set: issue_fire && dec_long && dec_rd != 0.
- Busy clear: lng_done clears busy[lng_rd]. Clear of rd 0 is ignored.
- Flush of an entry-1 long op clears its busy bit, recorded via a per-entry long flag.
- Same-cycle set and clear of the same rd: set wins.
- No bypass of the long-op result: a reader stalls in the lng_done cycle and issues the next cycle.
- stall_cycles increments when dec_valid && stall and saturates at all-ones.

## Timing
- Reset (synchronous): all entries invalid, busy=0, stall_cycles=0. During the reset cycle, issue_fire=0 and no busy update occurs.
- After reset: fwd_sel=0 and fwd_mem=0. stall then depends only on the dec_* inputs with busy=0, so it reads 0.
- Hazard outputs are combinational from registered state and the current dec_* inputs. Zero-cycle latency.
- An issued instruction is visible as entry 1 one cycle after issue_fire and as entry k k cycles later, provided no flush.
- Load-use with LOAD_LAT=2: dependent instruction stalls exactly 1 cycle, then issues with entry-2 select and fwd_mem=1.
- Reset asserted mid-long-op clears busy. A later lng_done for that op is harmless (clears an already-zero bit).

## Test plan
- ADD x5 issued, next cycle reader src0=x5 -> fwd_sel[0]=3'b001, fwd_mem=0, stall=0. One cycle later -> 3'b010, then 3'b100, then 3'b000.
- LW x7, next cycle reader src1=x7 -> stall=1 for 1 cycle, stall_cycles=1. Next cycle fwd_sel[1]=3'b010, fwd_mem[1]=1, issue_fire=1.
- Two writers of x3 in entries 1 and 2, reader src0=x3 -> 3'b001 (youngest wins). Reader of x0 with x0 writer in flight -> 3'b000, no stall.
- DIV x9 issued -> busy[9]=1. A reader of x9 and a writer of x9 both stall. lng_done lng_rd=9 -> busy[9]=0 next cycle; the reader issues that cycle.
- LW x4 in entry 1 with flush=1 -> entry 2 is invalid next cycle, and a reader of x4 gets no select and no stall. A flushed DIV x6 in entry 1 -> busy[6] cleared.
- Reset asserted with busy[9]=1 and entries valid -> next cycle busy=0, all fwd_sel=0, stall_cycles=0.
